run_monitor: RTL and testbench



---
 rtl/run_monitor_pkg.sv | 18 +
 rtl/sat_counter.sv | 27 ++
 rtl/run_monitor.sv | 145 ++++++++++++++
 tb/tb_run_monitor.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// Shared types for the run monitor: FSM states and terminal status codes.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_HOLD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STAT_NONE    = 2'd0,
    STAT_HALT    = 2'd1,
    STAT_TIMEOUT = 2'd2,
    STAT_STALL   = 2'd3
  } status_e;

endpackage : run_monitor_pkg

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] r_value;

  // Count up on inc, hold at all-ones, clear on reset or clr.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (rst || clr) begin
      r_value <= '0;
    end else if (inc && (r_value != {W{1'b1}})) begin
      r_value <= r_value + 1'b1;
    end
  end

  assign value = r_value;

endmodule : sat_counter

// File: rtl/run_monitor.sv
// Simulation run monitor: holds the core in reset after rst, counts RUN
// cycles and retirements, and ends the run on halt, cycle budget or stall.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_CYCLES  = 100000,
  parameter int STALL_LIMIT = 1000,
  parameter int CNT_W       = 32,
  parameter int CODE_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              retire_i,
  input  logic              halt_i,
  input  logic [CODE_W-1:0] halt_code_i,
  input  logic              ack_i,
  output logic              core_rst_o,
  output logic              running_o,
  output logic              done_o,
  output logic [1:0]        status_o,
  output logic [CODE_W-1:0] exit_code_o,
  output logic [CNT_W-1:0]  cycle_count_o,
  output logic [CNT_W-1:0]  retire_count_o
);

  localparam int STALL_W = $clog2(STALL_LIMIT + 1);

  state_e              r_state;
  state_e              w_state_nxt;
  status_e             r_status;
  status_e             w_status_nxt;
  logic [CODE_W-1:0]   r_exit_code;
  logic [CODE_W-1:0]   w_exit_code_nxt;
  logic [7:0]          r_hold_cnt;
  logic                r_core_rst;
  logic                r_running;
  logic                r_done;

  logic                w_in_run;
  logic                w_cnt_clr;
  logic                w_cycle_last;
  logic                w_stall_last;
  logic [CNT_W-1:0]    w_cycle_cnt;
  logic [CNT_W-1:0]    w_retire_cnt;
  logic [STALL_W-1:0]  w_stall_cnt;

  assign w_in_run  = (r_state == ST_RUN);
  // RESET always exits to HOLD, so clearing during RESET is the HOLD-entry clear.
  assign w_cnt_clr = (r_state == ST_RESET);

  // Wide compares so a limit larger than the counter can never alias.
  assign w_cycle_last = (64'(w_cycle_cnt) == 64'(MAX_CYCLES - 1));
  assign w_stall_last = (64'(w_stall_cnt) == 64'(STALL_LIMIT - 1));

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_cnt_clr),
    .inc   (w_in_run),
    .value (w_cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_cnt_clr),
    .inc   (w_in_run && retire_i),
    .value (w_retire_cnt)
  );

  sat_counter #(.W(STALL_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_cnt_clr || (w_in_run && retire_i)),
    .inc   (w_in_run && !retire_i),
    .value (w_stall_cnt)
  );

  // Next-state, status and exit-code selection; RUN exits by priority.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    w_state_nxt     = r_state;
    w_status_nxt    = r_status;
    w_exit_code_nxt = r_exit_code;
    unique case (r_state)
      ST_RESET: begin
        w_state_nxt     = ST_HOLD;
        w_status_nxt    = STAT_NONE;
        w_exit_code_nxt = '0;
      end
      ST_HOLD: begin
        if (r_hold_cnt == 8'(HOLD_CYCLES - 1)) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (halt_i) begin
          w_state_nxt     = ST_DONE;
          w_status_nxt    = STAT_HALT;
          w_exit_code_nxt = halt_code_i;
        end else if (w_cycle_last) begin
          w_state_nxt  = ST_DONE;
          w_status_nxt = STAT_TIMEOUT;
        end else if (w_stall_last && !retire_i) begin
          w_state_nxt  = ST_DONE;
          w_status_nxt = STAT_STALL;
        end
      end
      ST_DONE: begin
        if (ack_i) w_state_nxt = ST_RESET;
      end
      default: w_state_nxt = ST_RESET;
    endcase
  end

  // State and registered outputs; outputs decode the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RESET;
      r_status    <= STAT_NONE;
      r_exit_code <= '0;
      r_hold_cnt  <= '0;
      r_core_rst  <= 1'b1;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_status    <= w_status_nxt;
      r_exit_code <= w_exit_code_nxt;
      r_hold_cnt  <= (r_state == ST_HOLD) ? r_hold_cnt + 8'd1 : 8'd0;
      r_core_rst  <= (w_state_nxt != ST_RUN);
      r_running   <= (w_state_nxt == ST_RUN);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign core_rst_o     = r_core_rst;
  assign running_o      = r_running;
  assign done_o         = r_done;
  assign status_o       = r_status;
  assign exit_code_o    = r_exit_code;
  assign cycle_count_o  = w_cycle_cnt;
  assign retire_count_o = w_retire_cnt;

endmodule : run_monitor

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: reset release, halt, timeout, stall,
// priority, ack/rerun, reset abort, and counter saturation.
module tb_run_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: HOLD=4, MAX=200, STALL=10, 32-bit counters.
  logic        a_rst = 1'b1, a_retire = 1'b0, a_halt = 1'b0, a_ack = 1'b0;
  logic [7:0]  a_code = 8'h00;
  logic        a_core_rst, a_running, a_done;
  logic [1:0]  a_status;
  logic [7:0]  a_exit;
  logic [31:0] a_cyc, a_ret;

  // Instance B: 4-bit counters for saturation.
  logic        b_rst = 1'b1, b_retire = 1'b0, b_halt = 1'b0, b_ack = 1'b0;
  logic [7:0]  b_code = 8'h00;
  logic        b_core_rst, b_running, b_done;
  logic [1:0]  b_status;
  logic [7:0]  b_exit;
  logic [3:0]  b_cyc, b_ret;

  int vectors = 0;
  int errors  = 0;

  run_monitor #(.HOLD_CYCLES(4), .MAX_CYCLES(200), .STALL_LIMIT(10),
                .CNT_W(32), .CODE_W(8)) u_a (
    .clk(clk), .rst(a_rst), .retire_i(a_retire), .halt_i(a_halt),
    .halt_code_i(a_code), .ack_i(a_ack), .core_rst_o(a_core_rst),
    .running_o(a_running), .done_o(a_done), .status_o(a_status),
    .exit_code_o(a_exit), .cycle_count_o(a_cyc), .retire_count_o(a_ret)
  );

  run_monitor #(.HOLD_CYCLES(4), .MAX_CYCLES(100), .STALL_LIMIT(100),
                .CNT_W(4), .CODE_W(8)) u_b (
    .clk(clk), .rst(b_rst), .retire_i(b_retire), .halt_i(b_halt),
    .halt_code_i(b_code), .ack_i(b_ack), .core_rst_o(b_core_rst),
    .running_o(b_running), .done_o(b_done), .status_o(b_status),
    .exit_code_o(b_exit), .cycle_count_o(b_cyc), .retire_count_o(b_ret)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one posedge, then settle 1 time unit before sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // From DONE: ack, pass through RESET and HOLD, land in the first RUN cycle.
  task automatic a_ack_to_run();
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    ticks(5);
  endtask

  initial begin
    // ---------------- reset state ----------------
    ticks(5);
    check("rst_core_rst", a_core_rst, 1);
    check("rst_running",  a_running, 0);
    check("rst_done",     a_done, 0);
    check("rst_status",   a_status, 0);
    check("rst_cycles",   a_cyc, 0);

    // ---------------- reset release ----------------
    a_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_core_rst", a_core_rst, 1);
      check("hold_running",  a_running, 0);
    end
    tick();
    check("rel_core_rst", a_core_rst, 0);
    check("rel_running",  a_running, 1);
    check("rel_cycles",   a_cyc, 0);

    // ---------------- normal halt on RUN cycle 50 ----------------
    a_retire = 1'b1;
    ticks(49);
    check("pre_halt_done", a_done, 0);
    a_halt = 1'b1;
    a_code = 8'h2A;
    tick();
    check("halt_done",     a_done, 1);
    check("halt_status",   a_status, 1);
    check("halt_code",     a_exit, 8'h2A);
    check("halt_cycles",   a_cyc, 50);
    check("halt_retires",  a_ret, 50);
    check("halt_core_rst", a_core_rst, 1);
    check("halt_running",  a_running, 0);

    // DONE ignores halt/retire
    a_code = 8'h55;
    ticks(3);
    check("done_hold_code",    a_exit, 8'h2A);
    check("done_hold_retires", a_ret, 50);
    check("done_hold_status",  a_status, 1);
    a_halt   = 1'b0;
    a_retire = 1'b0;

    // ---------------- ack: counters hold through RESET, clear on HOLD ----------------
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    check("ack_done",      a_done, 0);
    check("ack_core_rst",  a_core_rst, 1);
    check("ack_cycles_kept", a_cyc, 50);
    tick();
    check("hold_entry_cycles",  a_cyc, 0);
    check("hold_entry_retires", a_ret, 0);
    ticks(4);
    check("rerun_running", a_running, 1);

    // ---------------- timeout at 200 RUN cycles ----------------
    for (int i = 0; i < 199; i++) begin
      a_retire = (i % 2 == 0);
      tick();
    end
    check("pre_to_done",   a_done, 0);
    check("pre_to_cycles", a_cyc, 199);
    a_retire = 1'b0;
    tick();
    check("to_done",    a_done, 1);
    check("to_status",  a_status, 2);
    check("to_cycles",  a_cyc, 200);
    check("to_retires", a_ret, 100);

    // ---------------- stall after 3 retires ----------------
    a_ack_to_run();
    a_retire = 1'b1;
    ticks(3);
    a_retire = 1'b0;
    ticks(9);
    check("pre_stall_done", a_done, 0);
    tick();
    check("stall_done",    a_done, 1);
    check("stall_status",  a_status, 3);
    check("stall_retires", a_ret, 3);
    check("stall_cycles",  a_cyc, 13);

    // ---------------- halt beats stall on the same cycle ----------------
    a_ack_to_run();
    a_retire = 1'b1;
    ticks(3);
    a_retire = 1'b0;
    ticks(9);
    a_halt = 1'b1;
    a_code = 8'h07;
    tick();
    a_halt = 1'b0;
    check("prio_status", a_status, 1);
    check("prio_code",   a_exit, 8'h07);

    // ---------------- rst in DONE loses status ----------------
    a_rst = 1'b1;
    tick();
    check("rst_done_done",   a_done, 0);
    check("rst_done_status", a_status, 0);
    check("rst_done_code",   a_exit, 0);

    // ---------------- rst mid-RUN ----------------
    a_rst = 1'b0;
    ticks(5);
    check("mid_running", a_running, 1);
    a_retire = 1'b1;
    ticks(5);
    check("mid_retires", a_ret, 5);
    a_rst = 1'b1;
    tick();
    a_retire = 1'b0;
    check("mid_core_rst", a_core_rst, 1);
    check("mid_running0", a_running, 0);
    check("mid_cycles",   a_cyc, 0);
    check("mid_retires0", a_ret, 0);

    // ---------------- saturation on 4-bit counters ----------------
    b_rst = 1'b0;
    ticks(5);
    check("sat_running", b_running, 1);
    for (int i = 0; i < 30; i++) begin
      b_retire = (i % 2 == 0);
      tick();
    end
    b_retire = 1'b0;
    check("sat_cycles", b_cyc, 15);
    check("sat_done",   b_done, 0);
    b_halt = 1'b1;
    b_code = 8'hC3;
    tick();
    b_halt = 1'b0;
    check("sat_halt_status", b_status, 1);
    check("sat_halt_cycles", b_cyc, 15);
    check("sat_halt_code",   b_exit, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_run_monitor
